modulo_varredura_matriz: RTL and testbench
==========================================

Name: modulo_varredura_matriz

Overview:
Sequential scan generator that sits directly upstream of the 1:16 demultiplexer selector.
- Walks the LED-matrix position space and produces the 3-bit column index (mdc) and 3-bit row index (mdl) that the selector decodes.
- Column is the fast index and row is the slow index.
- Each position is held for PRESCALE clocks.
- An optional blanking window between positions suppresses ghosting.

Parameters:
PRESCALE, 50000, clocks per scan position (dwell); legal range 2..2^20.
NUM_COLS, 5, columns scanned (mdc range 0..NUM_COLS-1); legal range 1..8.
NUM_ROWS, 7, rows scanned (mdl range 0..NUM_ROWS-1); legal range 1..8.
BLANK_CYCLES, 2, clocks at the start of each dwell during which scan_valid is low; must be < PRESCALE; 0 disables blanking.

Ports:
clk  in  1  system clock; the only clock.
reset_n  in  1  asynchronous active-low reset.
enable  in  1  scan run request.
hold  in  1  freeze scan (prescaler and position) while high.
mdc  out  3  current column index to the selector.
mdl  out  3  current row index to the selector.
scan_valid  out  1  position stable and outside the blank window; downstream drivers gate output on this.
col_strobe  out  1  one-clock pulse in the cycle a new position is presented.
frame_done  out  1  one-clock pulse when the scan wraps from the last position back to (0,0).

Behaviour:
- Reset (async assert, sync release): state=IDLE, mdc=0, mdl=0, scan_valid=0, col_strobe=0, frame_done=0, prescaler=0.
- FSM states:
  - IDLE: outputs held at their reset values. enable=1 goes to BLANK (BLANK_CYCLES>0) or SCAN (BLANK_CYCLES=0) on the next clock, with col_strobe=1 in that first cycle and position (0,0).
  - BLANK: scan_valid=0. Leaves for SCAN when prescaler==BLANK_CYCLES-1.
  - SCAN: scan_valid=1.
- Prescaler:
  - Counts 0..PRESCALE-1 in BLANK and SCAN. The terminal count is the advance tick.
  - On the tick: prescaler goes to 0, position advances, col_strobe=1 next cycle, and the state goes to BLANK (or stays in SCAN if BLANK_CYCLES=0).
- Advance rule:
  - If mdc<NUM_COLS-1: mdc+1.
  - Else mdc=0 and mdl+1.
  - If mdc=NUM_COLS-1 and mdl=NUM_ROWS-1: both go to 0, and frame_done=1 in the same cycle the (0,0) position appears (coincident with col_strobe).
- Arithmetic: internal counters sized by $clog2. mdc and mdl are zero-extended to 3 bits and never exceed NUM_COLS-1 and NUM_ROWS-1.
- hold=1 in BLANK or SCAN:
  - Prescaler, position and state are frozen; scan_valid keeps its value; no pulses are generated.
  - A tick that would have occurred in a held cycle is deferred, not lost.
- enable=0 in any non-IDLE state: next clock goes to IDLE, position and prescaler go to 0, scan_valid=0. enable has priority over hold.
- enable and hold both rising from IDLE: move to BLANK/SCAN as normal, then freeze.
- Reset mid-frame: immediate return to the reset values; no frame_done is emitted.
- NUM_COLS=1 and NUM_ROWS=1: every tick asserts frame_done and col_strobe; the position stays (0,0).

Optional Feature:
SERPENTINE_SCAN_EN
- Defined: odd rows scan columns descending (NUM_COLS-1 down to 0); even rows scan ascending.
  - Row advance occurs at the last column of the row's direction.
  - On entry to an odd row, mdc starts at NUM_COLS-1; on entry to an even row, mdc starts at 0.
  - The frame ends at the last position of row NUM_ROWS-1 and returns to (0,0).
- Undefined: every row scans ascending, as in Behaviour.

Decomposition:
- Shared package modulo_varredura_pkg holds:
  - FSM state encoding (IDLE=2'd0, BLANK=2'd1, SCAN=2'd2);
  - default constants MATRIZ_COLS=5 and MATRIZ_ROWS=7;
  - index width constant IDX_W=3.
- One natural sub-module: modulo_prescaler (count, hold, clear, terminal-tick output), instantiated once.
- The FSM and the position counters stay in the top module.

Test Plan:
1. PRESCALE=4, BLANK_CYCLES=1, enable rises after reset -> first cycle col_strobe=1 at (0,0) with scan_valid=0; scan_valid=1 for 3 clocks; mdc=1 after 4 clocks.
2. Full frame with NUM_COLS=5, NUM_ROWS=7, PRESCALE=4 -> sequence (0,0),(1,0)..(4,0),(0,1)..(4,6); frame_done pulses exactly once every 140 clocks, coincident with return to (0,0).
3. hold=1 for 10 clocks at (2,3), prescaler=1 -> outputs unchanged and no pulses; after release, advance to (3,3) exactly 3 clocks later.
4. enable=0 while at (4,5), hold=1 -> next clock IDLE, mdc=mdl=0, scan_valid=0, no frame_done.
5. reset_n low asynchronously mid-dwell -> all outputs 0 without waiting for a clock edge; after release, stays in IDLE until enable=1.
6. SERPENTINE_SCAN_EN defined, NUM_COLS=5 -> row 0 columns 0..4, row 1 columns 4..0, row 2 columns 0..4; after (0,6)... final position (4,6) (row 6 is even), then wrap to (0,0) with frame_done=1.

Source files
------------

// File: rtl/modulo_varredura_matriz_pkg.sv
// Shared types and constants for the LED-matrix scan generator.
package modulo_varredura_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SCAN  = 2'd2
  } state_e;

  localparam int unsigned MATRIZ_COLS = 5;
  localparam int unsigned MATRIZ_ROWS = 7;
  localparam int unsigned IDX_W       = 3;

  // Counter width for a 0..n-1 range, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/modulo_varredura_matriz_if.sv
// Control/status bundle between the scan generator and its controller.
interface modulo_varredura_matriz_if;
  import modulo_varredura_pkg::*;

  logic             enable;
  logic             hold;
  logic [IDX_W-1:0] mdc;
  logic [IDX_W-1:0] mdl;
  logic             scan_valid;
  logic             col_strobe;
  logic             frame_done;

  modport master (
    output enable, hold,
    input  mdc, mdl, scan_valid, col_strobe, frame_done
  );

  modport slave (
    input  enable, hold,
    output mdc, mdl, scan_valid, col_strobe, frame_done
  );

endinterface

// File: rtl/modulo_varredura_matriz_prescaler.sv
// Dwell prescaler: counts 0..PRESCALE-1 with clear and freeze; tick flags the terminal count.
module modulo_prescaler #(
  parameter int unsigned PRESCALE = 50000,
  parameter int unsigned CNT_W    = $clog2(PRESCALE)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             hold,
  output logic [CNT_W-1:0] count,
  output logic             tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] count_d, count_q;

  assign tick  = (count_q == LAST);
  assign count = count_q;

  always_comb begin
    count_d = count_q;
    if (clear)      count_d = '0;
    else if (hold)  count_d = count_q;
    else if (tick)  count_d = '0;
    else            count_d = count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

endmodule

// File: rtl/modulo_varredura_matriz.sv
// LED-matrix scan generator: column-fast/row-slow position walk with dwell and blanking.
// Optional SERPENTINE_SCAN_EN: odd rows scan columns in descending order.
module modulo_varredura_matriz
  import modulo_varredura_pkg::*;
#(
  parameter int unsigned PRESCALE     = 50000,
  parameter int unsigned NUM_COLS     = MATRIZ_COLS,
  parameter int unsigned NUM_ROWS     = MATRIZ_ROWS,
  parameter int unsigned BLANK_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      reset_n,
  modulo_varredura_matriz_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(PRESCALE);
  localparam int unsigned CW    = idx_width(NUM_COLS);
  localparam int unsigned RW    = idx_width(NUM_ROWS);

  localparam logic [CW-1:0]    COL_LAST    = CW'(NUM_COLS - 1);
  localparam logic [RW-1:0]    ROW_LAST    = RW'(NUM_ROWS - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST  = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam state_e           DWELL_START = (BLANK_CYCLES > 0) ? BLANK : SCAN;
  localparam logic             START_VALID = (BLANK_CYCLES == 0);

  state_e           state_d, state_q;
  logic [CW-1:0]    col_d, col_q, adv_col;
  logic [RW-1:0]    row_d, row_q, adv_row;
  logic             scan_valid_d, scan_valid_q;
  logic             col_strobe_d, col_strobe_q;
  logic             frame_done_d, frame_done_q;
  logic             adv_wrap, descending, col_end;
  logic [CW-1:0]    row_start_col;
  logic [CNT_W-1:0] count;
  logic             tick;

  modulo_prescaler #(
    .PRESCALE (PRESCALE),
    .CNT_W    (CNT_W)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (reset_n),
    .clear ((state_q == IDLE) || !bus.enable),
    .hold  (bus.hold),
    .count (count),
    .tick  (tick)
  );

`ifdef SERPENTINE_SCAN_EN
  assign descending    = row_q[0];
  assign row_start_col = row_q[0] ? '0 : COL_LAST;
`else
  assign descending    = 1'b0;
  assign row_start_col = '0;
`endif

  assign col_end = descending ? (col_q == '0) : (col_q == COL_LAST);

  // Next scan position; the row steps when the column reaches the end of its direction.
  always_comb begin
    adv_col  = col_q;
    adv_row  = row_q;
    adv_wrap = 1'b0;
    if (!col_end) begin
      adv_col = descending ? col_q - CW'(1) : col_q + CW'(1);
    end else if (row_q == ROW_LAST) begin
      adv_col  = '0;
      adv_row  = '0;
      adv_wrap = 1'b1;
    end else begin
      adv_col = row_start_col;
      adv_row = row_q + RW'(1);
    end
  end

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    scan_valid_d = scan_valid_q;
    col_strobe_d = 1'b0;
    frame_done_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.enable) begin
          state_d      = DWELL_START;
          col_d        = '0;
          row_d        = '0;
          scan_valid_d = START_VALID;
          col_strobe_d = 1'b1;
        end
      end
      BLANK, SCAN: begin
        // enable outranks hold: dropping enable always returns to IDLE.
        if (!bus.enable) begin
          state_d      = IDLE;
          col_d        = '0;
          row_d        = '0;
          scan_valid_d = 1'b0;
        end else if (!bus.hold) begin
          if (tick) begin
            state_d      = DWELL_START;
            col_d        = adv_col;
            row_d        = adv_row;
            scan_valid_d = START_VALID;
            col_strobe_d = 1'b1;
            frame_done_d = adv_wrap;
          end else if (state_q == BLANK && count == BLANK_LAST) begin
            state_d      = SCAN;
            scan_valid_d = 1'b1;
          end
        end
      end
      default: begin
        state_d      = IDLE;
        col_d        = '0;
        row_d        = '0;
        scan_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      col_q        <= '0;
      row_q        <= '0;
      scan_valid_q <= 1'b0;
      col_strobe_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      scan_valid_q <= scan_valid_d;
      col_strobe_q <= col_strobe_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.mdc        = IDX_W'(col_q);
  assign bus.mdl        = IDX_W'(row_q);
  assign bus.scan_valid = scan_valid_q;
  assign bus.col_strobe = col_strobe_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_modulo_varredura_matriz.sv
// Self-checking bench: directed table, corner-case sequences and random stimulus vs a dwell-time model.
module tb_modulo_varredura_matriz;

`ifdef SERPENTINE_SCAN_EN
  localparam bit SERP = 1'b1;
`else
  localparam bit SERP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  modulo_varredura_matriz_if aif ();
  modulo_varredura_matriz_if bif ();

  modulo_varredura_matriz #(
    .PRESCALE(4), .NUM_COLS(5), .NUM_ROWS(7), .BLANK_CYCLES(1)
  ) dut_a (.clk(clk), .reset_n(reset_n), .bus(aif));

  modulo_varredura_matriz #(
    .PRESCALE(2), .NUM_COLS(1), .NUM_ROWS(1), .BLANK_CYCLES(0)
  ) dut_b (.clk(clk), .reset_n(reset_n), .bus(bif));

  typedef struct packed {
    logic [2:0] mdc;
    logic [2:0] mdl;
    logic       sv;
    logic       cs;
    logic       fd;
  } out_t;

  // Model state: t = running cycles since enable (held cycles excluded).
  typedef struct {
    int unsigned t;
    bit          run;
    bit          fresh;
  } mstate_t;

  typedef struct {
    logic en;
    logic hd;
    out_t exp;
  } vec_t;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  mstate_t ma, mb;

  function automatic mstate_t m_step(input mstate_t s, input logic en, input logic hd);
    mstate_t n = s;
    if (!s.run) begin
      n.t = 0; n.run = en; n.fresh = en;
    end else if (!en) begin
      n.t = 0; n.run = 1'b0; n.fresh = 1'b0;
    end else if (hd) begin
      n.fresh = 1'b0;
    end else begin
      n.t = s.t + 1; n.fresh = 1'b1;
    end
    return n;
  endfunction

  function automatic out_t m_out(input mstate_t s, input int unsigned p, input int unsigned c,
                                 input int unsigned r, input int unsigned b);
    out_t o = '0;
    int unsigned idx, ph, row, col;
    if (s.run) begin
      idx = (s.t / p) % (c * r);
      ph  = s.t % p;
      row = idx / c;
      col = idx % c;
      if (SERP && (row % 2 == 1)) col = c - 1 - col;
      o.mdc = 3'(col);
      o.mdl = 3'(row);
      o.sv  = (ph >= b);
      o.cs  = s.fresh && (ph == 0);
      o.fd  = o.cs && (idx == 0) && (s.t > 0);
    end
    return o;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ma <= '{0, 1'b0, 1'b0};
      mb <= '{0, 1'b0, 1'b0};
    end else begin
      ma <= m_step(ma, aif.enable, aif.hold);
      mb <= m_step(mb, bif.enable, bif.hold);
    end
  end

  function automatic out_t pack_a();
    return {aif.mdc, aif.mdl, aif.scan_valid, aif.col_strobe, aif.frame_done};
  endfunction

  function automatic out_t pack_b();
    return {bif.mdc, bif.mdl, bif.scan_valid, bif.col_strobe, bif.frame_done};
  endfunction

  function automatic vec_t mk(input logic en, input logic hd, input int unsigned c, input int unsigned r,
                              input logic sv, input logic cs, input logic fd);
    vec_t v;
    v.en = en; v.hd = hd;
    v.exp = {3'(c), 3'(r), sv, cs, fd};
    return v;
  endfunction

  task automatic cmp(input string name, input out_t act, input out_t exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got mdc=%0d mdl=%0d sv=%b cs=%b fd=%b, expected mdc=%0d mdl=%0d sv=%b cs=%b fd=%b",
               name, act.mdc, act.mdl, act.sv, act.cs, act.fd, exp.mdc, exp.mdl, exp.sv, exp.cs, exp.fd);
    end
  endtask

  task automatic cmp_int(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cmp("model_a", pack_a(), m_out(ma, 4, 5, 7, 1));
    cmp("model_b", pack_b(), m_out(mb, 2, 1, 1, 0));
  endtask

  task automatic wait_strobe_at(input int unsigned c, input int unsigned r);
    bit found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      step();
      if (aif.col_strobe && aif.mdc == 3'(c) && aif.mdl == 3'(r)) found = 1'b1;
    end
    if (!found) cmp_int("wait_position_timeout", 0, 1);
  endtask

  task automatic wait_next_strobe();
    bit found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (aif.col_strobe) found = 1'b1;
    end
    if (!found) cmp_int("wait_strobe_timeout", 0, 1);
  endtask

  vec_t tbl [17];

  initial begin
    int unsigned n;
    bit done;

    aif.enable = 1'b0; aif.hold = 1'b0;
    bif.enable = 1'b1; bif.hold = 1'b0;

    // enable rises after reset; dwell 4 with one blank clock, holds and enable drops mixed in.
    tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(1, 0, 0, 0, 0, 1, 0);
    tbl[3]  = mk(1, 0, 0, 0, 1, 0, 0);
    tbl[4]  = mk(1, 0, 0, 0, 1, 0, 0);
    tbl[5]  = mk(1, 0, 0, 0, 1, 0, 0);
    tbl[6]  = mk(1, 0, 1, 0, 0, 1, 0);
    tbl[7]  = mk(1, 0, 1, 0, 1, 0, 0);
    tbl[8]  = mk(1, 1, 1, 0, 1, 0, 0);
    tbl[9]  = mk(1, 0, 1, 0, 1, 0, 0);
    tbl[10] = mk(1, 0, 1, 0, 1, 0, 0);
    tbl[11] = mk(1, 0, 2, 0, 0, 1, 0);
    tbl[12] = mk(0, 0, 0, 0, 0, 0, 0);
    tbl[13] = mk(0, 0, 0, 0, 0, 0, 0);
    tbl[14] = mk(1, 1, 0, 0, 0, 1, 0);
    tbl[15] = mk(1, 1, 0, 0, 0, 0, 0);
    tbl[16] = mk(1, 0, 0, 0, 1, 0, 0);

    step();
    cmp("reset_state_a", pack_a(), '0);
    cmp("reset_state_b", pack_b(), '0);
    step();
    reset_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      aif.enable = tbl[i].en;
      aif.hold   = tbl[i].hd;
      step();
      cmp($sformatf("table_%0d", i), pack_a(), tbl[i].exp);
    end

    // Frame period with free-running scan.
    aif.enable = 1'b1; aif.hold = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      step();
      if (aif.frame_done) done = 1'b1;
    end
    if (!done) cmp_int("first_frame_timeout", 0, 1);
    n = 0; done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      step();
      n++;
      if (aif.frame_done) done = 1'b1;
    end
    cmp_int("frame_period", int'(n), 140);
    cmp("frame_wrap_outputs", pack_a(), {3'd0, 3'd0, 1'b0, 1'b1, 1'b1});

    // Hold for 10 clocks at (2,3) with the prescaler at 1, then resume.
    wait_strobe_at(2, 3);
    step();
    aif.hold = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      cmp("hold_freeze", pack_a(), {3'd2, 3'd3, 1'b1, 1'b0, 1'b0});
    end
    aif.hold = 1'b0;
    n = 0; done = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin
      step();
      n++;
      if (aif.mdc != 3'd2) done = 1'b1;
    end
    cmp_int("hold_resume_latency", int'(n), 3);
    cmp_int("hold_resume_col", int'(aif.mdc), SERP ? 1 : 3);

    // Drop enable while held at (4,5).
    wait_strobe_at(4, 5);
    aif.hold = 1'b1; aif.enable = 1'b0;
    step();
    cmp("disable_under_hold", pack_a(), '0);
    aif.hold = 1'b0;
    step();
    cmp("idle_after_disable", pack_a(), '0);

    // Row turn and final wrap.
    aif.enable = 1'b1;
    wait_strobe_at(4, 0);
    wait_next_strobe();
    cmp("row_turn", pack_a(), SERP ? {3'd4, 3'd1, 1'b0, 1'b1, 1'b0} : {3'd0, 3'd1, 1'b0, 1'b1, 1'b0});
    wait_strobe_at(4, 6);
    wait_next_strobe();
    cmp("last_to_origin", pack_a(), {3'd0, 3'd0, 1'b0, 1'b1, 1'b1});

    // Asynchronous reset in mid-dwell.
    repeat (37) step();
    #2;
    reset_n = 1'b0;
    #1;
    cmp("async_reset_a", pack_a(), '0);
    cmp("async_reset_b", pack_b(), '0);
    @(posedge clk);
    #1;
    aif.enable = 1'b0;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      cmp("idle_after_reset", pack_a(), '0);
    end
    aif.enable = 1'b1;
    step();
    cmp("restart_after_reset", pack_a(), {3'd0, 3'd0, 1'b0, 1'b1, 1'b0});

    // Random enable/hold traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      aif.enable = ($urandom_range(0, 63) != 0);
      aif.hold   = ($urandom_range(0, 7) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
